// File: rtl/ssd_scan_tick_gen.sv
// Scan tick / divided clock / rotating digit select generator for an
// N-digit multiplexed seven-segment display, with run-time divide value.
module ssd_scan_tick_gen #(
  parameter int CNT_W       = 20,
  parameter int DEFAULT_DIV = 833333,
  parameter int NUM_DIGITS  = 4,
  localparam int SEL_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [CNT_W-1:0]      div_in,
  output logic                  tick,
  output logic                  divided_clk,
  output logic [SEL_W-1:0]      digit_sel,
  output logic [NUM_DIGITS-1:0] an,
  output logic [CNT_W-1:0]      div_cur
);

  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_div;
  logic                  r_tick;
  logic                  r_dclk;
  logic [SEL_W-1:0]      r_sel;
  logic [NUM_DIGITS-1:0] r_an;

  logic                  w_tc;
  logic [SEL_W-1:0]      w_sel_next;
  logic [NUM_DIGITS-1:0] w_an_next;

  assign w_tc = (r_cnt == r_div);

  // Explicit wrap keeps the select inside 0..NUM_DIGITS-1 for non-power-of-2 counts.
  always_comb begin
    w_sel_next = '0;
    if (r_sel != SEL_W'(NUM_DIGITS - 1))
      w_sel_next = r_sel + SEL_W'(1);
    w_an_next = ~(NUM_DIGITS'(1) << w_sel_next);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_div  <= CNT_W'(DEFAULT_DIV);
      r_tick <= 1'b0;
      r_dclk <= 1'b0;
      r_sel  <= '0;
      r_an   <= ~NUM_DIGITS'(1);
    end else if (load) begin
      // A terminal count coinciding with load is dropped on purpose.
      r_div  <= div_in;
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!enable) begin
      r_tick <= 1'b0;
    end else if (w_tc) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
      r_dclk <= ~r_dclk;
      r_sel  <= w_sel_next;
      r_an   <= w_an_next;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign tick        = r_tick;
  assign divided_clk = r_dclk;
  assign digit_sel   = r_sel;
  assign an          = r_an;
  assign div_cur     = r_div;

endmodule

// File: tb/tb_ssd_scan_tick_gen.sv
// Directed bench: 4-digit and 3-digit instances (DEFAULT_DIV=3) driven by
// shared stimulus; expected values derived from the count of terminal events.
module tb_ssd_scan_tick_gen;

  localparam int CNT_W = 20;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             load;
  logic [CNT_W-1:0] div_in;

  logic             tick4, dclk4;
  logic [1:0]       sel4;
  logic [3:0]       an4;
  logic [CNT_W-1:0] div4;

  logic             tick3, dclk3;
  logic [1:0]       sel3;
  logic [2:0]       an3;
  logic [CNT_W-1:0] div3;

  int n_tests = 0;
  int n_fail  = 0;
  int n_tc    = 0;

  always #5 clk_in = ~clk_in;

  ssd_scan_tick_gen #(.CNT_W(CNT_W), .DEFAULT_DIV(3), .NUM_DIGITS(4)) dut4 (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .load(load), .div_in(div_in),
    .tick(tick4), .divided_clk(dclk4), .digit_sel(sel4), .an(an4), .div_cur(div4)
  );

  ssd_scan_tick_gen #(.CNT_W(CNT_W), .DEFAULT_DIV(3), .NUM_DIGITS(3)) dut3 (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .load(load), .div_in(div_in),
    .tick(tick3), .divided_clk(dclk3), .digit_sel(sel3), .an(an3), .div_cur(div3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Check both instances against the state implied by n_tc terminal events.
  task automatic check_all(input string tag, input logic exp_tick, input int exp_div);
    int s4, s3;
    s4 = n_tc % 4;
    s3 = n_tc % 3;
    check({tag, " tick4"}, 32'(tick4), 32'(exp_tick));
    check({tag, " dclk4"}, 32'(dclk4), 32'(n_tc % 2));
    check({tag, " sel4"},  32'(sel4),  32'(s4));
    check({tag, " an4"},   32'(an4),   32'(4'hF ^ (4'h1 << s4)));
    check({tag, " div4"},  32'(div4),  32'(exp_div));
    check({tag, " tick3"}, 32'(tick3), 32'(exp_tick));
    check({tag, " sel3"},  32'(sel3),  32'(s3));
    check({tag, " an3"},   32'(an3),   32'(3'h7 ^ (3'h1 << s3)));
    check({tag, " div3"},  32'(div3),  32'(exp_div));
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; div_in = '0;
    step();
    step();
    check_all("reset", 1'b0, 3);

    // Free run with D=3: tick every 4th edge.
    rst_n = 1'b1; enable = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      if (k % 4 == 0) n_tc++;
      step();
      check_all("run", 1'(k % 4 == 0), 3);
    end

    // cnt is now 2; freeze for 10 cycles.
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check_all("pause", 1'b0, 3);
    end
    enable = 1'b1;
    step();
    check_all("resume1", 1'b0, 3);
    n_tc++;
    step();
    check_all("resume2", 1'b1, 3);

    // Load on the terminal-count edge: no tick, no advance.
    for (int k = 0; k < 3; k++) begin
      step();
      check_all("pre_load", 1'b0, 3);
    end
    load = 1'b1; div_in = 20'd5;
    step();
    check_all("load_at_tc", 1'b0, 5);
    load = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) n_tc++;
      step();
      check_all("after_load", 1'(k == 6), 5);
    end

    // D=0: tick every cycle.
    load = 1'b1; div_in = 20'd0;
    step();
    check_all("load0", 1'b0, 0);
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tc++;
      step();
      check_all("d0", 1'b1, 0);
    end
    check("pre_rst dclk3", 32'(dclk3), 32'd1);
    check("pre_rst sel3", 32'(sel3), 32'd2);

    // Mid-count reset, then reset coinciding with load.
    rst_n = 1'b0;
    step();
    n_tc = 0;
    check_all("mid_reset", 1'b0, 3);
    check("mid_reset dclk3", 32'(dclk3), 32'd0);
    load = 1'b1; div_in = 20'd7;
    step();
    check_all("reset_vs_load", 1'b0, 3);
    rst_n = 1'b1; load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) n_tc++;
      step();
      check_all("post_reset", 1'(k == 4), 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
